serial_word_tx: RTL and testbench



---
 rtl/serial_word_tx_if.sv | 20 ++
 rtl/serial_word_tx.sv | 83 ++++++++
 tb/tb_serial_word_tx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/serial_word_tx_if.sv
// serial_word_tx_if: producer handshake and serial-output bundle for serial_word_tx
interface serial_word_tx_if #(parameter int WIDTH = 4);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic             ser_bit;
  logic             ser_sr;
  logic             ser_sl;
  logic             word_done;
  logic             busy;
  modport master (
    output in_valid, in_data, in_dir,
    input  in_ready, ser_bit, ser_sr, ser_sl, word_done, busy
  );
  modport slave (
    input  in_valid, in_data, in_dir,
    output in_ready, ser_bit, ser_sr, ser_sl, word_done, busy
  );
endinterface

// File: rtl/serial_word_tx.sv
// serial_word_tx: word-to-serial transmitter driving shift strobes of a downstream shift register
module serial_word_tx #(
  parameter int WIDTH = 4
) (
  input logic             clk,
  input logic             rst,
  serial_word_tx_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, hold_q, hold_d;
  logic             dir_q, dir_d, hdir_q, hdir_d, hfull_q, hfull_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             shifting, xfer, last;
  assign shifting      = state_q == SHIFT;
  assign last          = shifting && cnt_q == CW'(WIDTH - 1);
  assign xfer          = bus.in_valid && !hfull_q;
  assign bus.in_ready  = !hfull_q;
  assign bus.ser_bit   = shifting && (dir_q ? sh_q[WIDTH-1] : sh_q[0]);
  assign bus.ser_sr    = shifting && !dir_q;
  assign bus.ser_sl    = shifting && dir_q;
  assign bus.word_done = last;
  assign bus.busy      = shifting || hfull_q;
  // next state: load from producer or hold buffer, shift toward the emitted end, park extra word in hold
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    hdir_d  = hdir_q;
    hfull_d = hfull_q;
    if (!shifting) begin
      if (xfer) begin
        sh_d    = bus.in_data;
        dir_d   = bus.in_dir;
        cnt_d   = '0;
        state_d = SHIFT;
      end
    end else begin
      sh_d  = dir_q ? sh_q << 1 : sh_q >> 1;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        cnt_d = '0;
        if (hfull_q) begin
          sh_d    = hold_q;
          dir_d   = hdir_q;
          hfull_d = 1'b0;
        end else if (xfer) begin
          sh_d  = bus.in_data;
          dir_d = bus.in_dir;
        end else begin
          state_d = IDLE;
        end
      end else if (xfer) begin
        hold_d  = bus.in_data;
        hdir_d  = bus.in_dir;
        hfull_d = 1'b1;
      end
    end
  end
  // state registers; reset aborts any word in flight and empties the hold buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
      hdir_q  <= 1'b0;
      hfull_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      hdir_q  <= hdir_d;
      hfull_q <= hfull_d;
    end
  end
endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: randomized and directed self-checking bench against a bit-queue model
module tb_serial_word_tx;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  serial_word_tx_if #(.WIDTH(W)) bus ();
  serial_word_tx #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {logic b; logic sr; logic sl; logic done;} slot_t;
  slot_t        q[$];
  logic [W-1:0] words[$];
  int           done_at[$];
  int           checks = 0, errors = 0, cyc = 0, done_cnt = 0, strobes = 0, ready_low = 0;
  logic         started = 1'b0;
  logic [W-1:0] rx = '0, cap = '0, last_rx = '0, last_cap = '0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  // model: every accepted word appends its WIDTH serial slots; one slot retires per cycle
  always @(posedge clk) begin : model
    logic mready;
    mready = q.size() <= W;
    cyc++;
    if (rst) begin
      q.delete();
      words.delete();
      rx = '0;
      cap = '0;
      started = 1'b1;
    end else if (started) begin
      if (bus.ser_sr) rx = {bus.ser_bit, rx[W-1:1]};
      if (bus.ser_sl) rx = {rx[W-2:0], bus.ser_bit};
      if (bus.ser_sr || bus.ser_sl) cap = {cap[W-2:0], bus.ser_bit};
      if (bus.word_done) begin
        last_rx = rx;
        last_cap = cap;
        done_cnt++;
        done_at.push_back(cyc);
        chk("rx_pending", words.size() > 0, 1);
        if (words.size() > 0) chk("rx_word", rx, words.pop_front());
      end
      if (q.size() > 0) void'(q.pop_front());
      if (bus.in_valid && mready) begin
        for (int i = 0; i < W; i++)
          q.push_back('{b: bus.in_dir ? bus.in_data[W-1-i] : bus.in_data[i],
                        sr: !bus.in_dir, sl: bus.in_dir, done: i == W - 1});
        words.push_back(bus.in_data);
      end
    end
  end
  // compare every cycle on the falling edge
  always @(negedge clk) begin : compare
    slot_t e;
    if (started) begin
      e = q.size() > 0 ? q[0] : '0;
      chk("ser_bit", bus.ser_bit, e.b);
      chk("ser_sr", bus.ser_sr, e.sr);
      chk("ser_sl", bus.ser_sl, e.sl);
      chk("word_done", bus.word_done, e.done);
      chk("busy", bus.busy, q.size() > 0);
      chk("in_ready", bus.in_ready, q.size() <= W);
      if (bus.ser_sr || bus.ser_sl) strobes++;
      if (!bus.in_ready) ready_low++;
    end
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [W-1:0] d, input logic dr);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_dir   = dr;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", bus.in_ready, 1);
    bus.in_valid = 1'b0;
  endtask
  initial begin
    int d0, n0, s0, r0;
    logic seen;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_dir   = 1'b0;
    idle(2);
    rst = 1'b0;
    chk("reset_ready", bus.in_ready, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_bit", bus.ser_bit, 0);
    d0 = done_cnt;
    send(4'b1011, 1'b0);
    chk("lsb_first_bit", bus.ser_bit, 1);
    chk("lsb_sr", bus.ser_sr, 1);
    idle(W + 1);
    chk("lsb_bits", last_cap, 4'b1101);
    chk("lsb_rx", last_rx, 4'b1011);
    chk("lsb_done_cnt", done_cnt - d0, 1);
    send(4'b1011, 1'b1);
    chk("msb_sl", bus.ser_sl, 1);
    idle(W + 1);
    chk("msb_bits", last_cap, 4'b1011);
    chk("msb_rx", last_rx, 4'b1011);
    n0 = done_at.size();
    s0 = strobes;
    r0 = ready_low;
    send(4'hA, 1'b0);
    send(4'h5, 1'b1);
    send(4'hF, 1'b0);
    idle(3 * W + 2);
    chk("b2b_dones", done_at.size() - n0, 3);
    chk("b2b_strobes", strobes - s0, 12);
    chk("b2b_ready_dropped", ready_low > r0, 1);
    if (done_at.size() >= n0 + 3) begin
      chk("b2b_gap1", done_at[n0+1] - done_at[n0], 4);
      chk("b2b_gap2", done_at[n0+2] - done_at[n0+1], 4);
    end
    chk("b2b_last_rx", last_rx, 4'hF);
    send(4'h3, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = bus.word_done;
    end
    chk("edge_done_seen", seen, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h9;
    bus.in_dir   = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("edge_next_sr", bus.ser_sr, 1);
    chk("edge_ready", bus.in_ready, 1);
    idle(W + 1);
    chk("edge_bits", last_cap, 4'b1001);
    chk("edge_rx", last_rx, 4'h9);
    send(4'hC, 1'b0);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("abort_bit", bus.ser_bit, 0);
    chk("abort_sr", bus.ser_sr, 0);
    chk("abort_sl", bus.ser_sl, 0);
    chk("abort_done", bus.word_done, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_ready", bus.in_ready, 1);
    d0 = done_cnt;
    idle(W + 2);
    chk("abort_no_done", done_cnt - d0, 0);
    send(4'h6, 1'b1);
    idle(W + 1);
    chk("after_abort_bits", last_cap, 4'b0110);
    chk("after_abort_rx", last_rx, 4'h6);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      chk("gap_busy", bus.busy, 0);
      chk("gap_strobe", bus.ser_sr | bus.ser_sl, 0);
    end
    send(4'h2, 1'b0);
    chk("resume_sr", bus.ser_sr, 1);
    chk("resume_bit", bus.ser_bit, 0);
    idle(W + 1);
    chk("resume_rx", last_rx, 4'h2);
    for (int k = 0; k < 500; k++) begin
      rst          = $urandom_range(0, 99) == 0;
      bus.in_valid = $urandom_range(0, 2) != 0;
      bus.in_data  = W'($urandom);
      bus.in_dir   = 1'($urandom);
      idle(1);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    idle(2 * W + 2);
    chk("final_idle", bus.busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
